inst_prefetch_queue: RTL and testbench
======================================

INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rom_en  output  1  instruction ROM read request this cycle.
REQ-006 rom_addr  output  32  byte address of the requested word.
REQ-007 rom_data  input  32  ROM read data, valid exactly one cycle after rom_en.
REQ-008 redirect  input  1  branch/jump taken in decode; flush and refetch.
REQ-009 redirect_addr  input  32  new fetch address, sampled when redirect=1.
REQ-010 if_ready  input  1  Fetch_register accepts (high when not stalled by hazard control).
REQ-011 if_valid  output  1  queue head holds a valid instruction.
REQ-012 if_instr  output  32  head instruction.
REQ-013 if_pc_next  output  32  head fetch address + 4.

Function
REQ-014 Queue entry SHALL hold {instr, pc_next}; head presented combinationally from registered storage; pop when if_valid && if_ready.
REQ-015 Fetch PC register SHALL issue rom_en when occupancy + in-flight < DEPTH and redirect=0; rom_addr = fetch PC; fetch PC += 4 on each issue, 32-bit wrap.
REQ-016 At most one request in flight; response pushed at end of the arrival cycle with pc_next = request address + 4.
REQ-017 Simultaneous push and pop SHALL keep occupancy unchanged; push into a full queue SHALL never occur (guaranteed by REQ-015).
REQ-018 Pointers SHALL wrap modulo DEPTH; occupancy counter SHALL range 0..DEPTH.
REQ-019 redirect=1 in cycle N SHALL: empty queue and clear occupancy at end of N; load fetch PC = redirect_addr; drop any rom_data arriving in N+1 from a pre-redirect request; suppress rom_en in N.
REQ-020 After redirect in N: rom_en with rom_addr=redirect_addr in N+1, data in N+2, if_valid=1 in N+3.
REQ-021 redirect SHALL take priority over pop, push and issue in the same cycle; if_valid SHALL be 0 in N+1 and N+2.
REQ-022 if_instr and if_pc_next SHALL be stable while if_valid=1 and if_ready=0.
REQ-023 Steady state with if_ready held high: one instruction delivered per cycle after fill.

Reset
REQ-024 rst=1 SHALL set: occupancy 0, pointers 0, in-flight flag 0, drop flag 0, fetch PC=RESET_PC, if_valid=0, rom_en=0.
REQ-025 First cycle after rst deasserts SHALL issue rom_en with rom_addr=RESET_PC; if_valid=1 two cycles later.
REQ-026 rst asserted mid-fill SHALL discard in-flight data; rst has priority over redirect.

Configuration
REQ-027 Macro PREFETCH_JUMP_EN compiled in: on push of an instruction with instr[31:26]=6'd2, fetch PC SHALL load {pc_next[31:28], instr[25:0], 2'b00}, the sequential request issued in that cycle SHALL be dropped, and the jump itself SHALL still be enqueued.
REQ-028 Macro PREFETCH_JUMP_EN absent: no predecode; fetch strictly sequential, jumps resolved only via redirect.

Verification
REQ-029 Reset release, ROM word n = n, if_ready=1 -> rom_addr 0,4,8,... consecutive cycles; if_instr 0,1,2 from 2 cycles after release; if_pc_next 4,8,12.
REQ-030 if_ready=0 for 10 cycles after reset -> occupancy saturates at 4, rom_en low while full, head holds instr 0/pc_next 4; release -> 0,1,2,3,4 back-to-back with no gap or duplicate.
REQ-031 redirect=1, redirect_addr=32'h100 while 3 entries queued and one request in flight -> queue empty next cycle, stale response dropped, rom_addr 32'h100 in N+1, if_instr = word at 32'h100 in N+3.
REQ-032 redirect and pop in same cycle with queue full -> flush wins, no stale instruction ever presented.
REQ-033 rst pulsed mid-fill -> if_valid=0 next cycle, fetch restarts at RESET_PC.
REQ-034 PREFETCH_JUMP_EN: word at 32'h8 = J with target field 26'h40 -> jump enqueued, next delivered instruction from 32'h100, word at 32'hC never delivered; without macro, 32'hC follows 32'h8.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: keeps a small FIFO of {instr, pc_next} filled from a
// one-cycle-latency instruction ROM, with branch redirect flush.
// Optional build macro PREFETCH_JUMP_EN: predecode J-type (opcode 6'd2) on push and steer
// the fetch PC to the jump target without waiting for a redirect from decode.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_next
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            drop_q, drop_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     pcn_q   [DEPTH];

  logic        issue, push, pop, jump_push;
  logic [31:0] push_pc_next;
`ifdef PREFETCH_JUMP_EN
  logic [31:0] jump_target;
`endif

  // Handshake decode and head presentation; redirect outranks push, pop and issue.
  always_comb begin
    if_valid     = (occ_q != '0);
    if_instr     = instr_q[rd_ptr_q];
    if_pc_next   = pcn_q[rd_ptr_q];
    rom_addr     = fetch_pc_q;
    // Occupancy plus the word still arriving must leave room for the new request.
    issue        = !rst && !redirect && ((occ_q + CntW'(inflight_q)) < DepthCnt);
    rom_en       = issue;
    push         = inflight_q && !drop_q && !redirect;
    pop          = if_valid && if_ready && !redirect;
    push_pc_next = req_pc_q + 32'd4;
`ifdef PREFETCH_JUMP_EN
    jump_target  = {push_pc_next[31:28], rom_data[25:0], 2'b00};
    jump_push    = push && (rom_data[31:26] == 6'd2);
`else
    jump_push    = 1'b0;
`endif
  end

  // Next-state for fetch PC, request tracking, pointers and occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    drop_d     = 1'b0;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end

`ifdef PREFETCH_JUMP_EN
    // The sequential request issued alongside a jump push fetches the wrong path.
    if (jump_push) begin
      fetch_pc_d = jump_target;
      drop_d     = issue;
    end
`endif

    if (redirect) begin
      fetch_pc_d = redirect_addr;
      occ_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + CntW'(1);
        2'b01:   occ_d = occ_q - CntW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push && !jump_push) begin
      instr_q[wr_ptr_q] <= rom_data;
      pcn_q[wr_ptr_q]   <= push_pc_next;
    end else if (jump_push) begin
      instr_q[wr_ptr_q] <= rom_data;
      pcn_q[wr_ptr_q]   <= push_pc_next;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: directed scenarios followed by a randomized
// run, all checked against an address-stream model of what the fetch unit must deliver.
module tb_inst_prefetch_queue;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] JWord   = {6'd2, 26'h40};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic        if_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_next;

  always #5 clk = ~clk;

  inst_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (ResetPc)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .if_ready      (if_ready),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc_next    (if_pc_next)
  );

  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_total = 0;
  int          n_pops  = 0;
  int          since_rd = 99;
  logic        jump_word_en = 1'b0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] exp_pc = ResetPc;
  logic [31:0] last_rd_addr = 32'h0;
  logic        s_en, s_valid;
  logic [31:0] s_addr, s_instr, s_pcn;
  logic [31:0] delivered [$];

  // ROM image: word n holds n, optionally with a J instruction planted at 0x8.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (jump_word_en && a == 32'h8) return JWord;
    return a >> 2;
  endfunction

  // Address of the instruction that must follow the one at a.
  function automatic logic [31:0] next_pc(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] seq;
    seq = a + 32'd4;
`ifdef PREFETCH_JUMP_EN
    if (w[31:26] == 6'd2) return {seq[31:28], w[25:0], 2'b00};
`else
    if (w == 32'hFFFF_FFFF) return seq;
`endif
    return seq;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, sample settled outputs, run the model.
  task automatic tick(input logic r, input logic rd, input logic [31:0] ra, input logic rdy);
    logic p;
    @(negedge clk);
    rst           = r;
    redirect      = rd;
    redirect_addr = ra;
    if_ready      = rdy;
    rom_data      = prev_req ? word(prev_addr) : 32'hDEAD_BEEF;
    #1;
    s_en    = rom_en;
    s_addr  = rom_addr;
    s_valid = if_valid;
    s_instr = if_instr;
    s_pcn   = if_pc_next;
    prev_req  = s_en;
    prev_addr = s_addr;
    if (since_rd < 99) since_rd++;
    if (!r) begin
      if (rd) check("rom_en_in_redirect_cycle", 32'(s_en), 32'd0);
      if (since_rd == 1 && !rd) begin
        check("rom_en_after_redirect", 32'(s_en), 32'd1);
        check("rom_addr_after_redirect", s_addr, last_rd_addr);
      end
      if (since_rd == 1 || since_rd == 2)
        check("if_valid_low_after_redirect", 32'(s_valid), 32'd0);
      if (s_valid) begin
        check("head_instr", s_instr, word(exp_pc));
        check("head_pc_next", s_pcn, exp_pc + 32'd4);
      end
    end
    p = s_valid && rdy && !rd && !r;
    if (r) begin
      exp_pc   = ResetPc;
      since_rd = 99;
    end else if (rd) begin
      exp_pc       = ra;
      since_rd     = 0;
      last_rd_addr = ra;
    end else if (p) begin
      delivered.push_back(s_instr);
      exp_pc = next_pc(exp_pc, word(exp_pc));
      n_pops++;
    end
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    check("reset_if_valid", 32'(s_valid), 32'd0);
    check("reset_rom_en", 32'(s_en), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pops_before;
    logic        rdy, rd;
    logic [31:0] ra;

    // Reset release with if_ready high: sequential fetch and delivery.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("seq_rom_en", 32'(s_en), 32'd1);
      check("seq_rom_addr", s_addr, 32'(4 * k));
      if (k < 2) begin
        check("seq_fill_if_valid", 32'(s_valid), 32'd0);
      end else begin
        check("seq_if_valid", 32'(s_valid), 32'd1);
        check("seq_if_instr", s_instr, 32'(k - 2));
        check("seq_if_pc_next", s_pcn, 32'(4 * (k - 1)));
      end
    end

    // Stall for 10 cycles: fill saturates, then drains back-to-back.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      if (k >= 4) check("full_rom_en_low", 32'(s_en), 32'd0);
    end
    check("full_head_instr", s_instr, 32'd0);
    check("full_head_pc_next", s_pcn, 32'd4);
    delivered.delete();
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("drain_count", 32'(delivered.size()), 32'd5);
    if (delivered.size() == 5)
      for (int j = 0; j < 5; j++) check("drain_order", delivered[j], 32'(j));

    // Redirect with three queued and one in flight.
    do_reset();
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'h100, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_n1_if_valid", 32'(s_valid), 32'd0);
    check("redir_n1_rom_addr", s_addr, 32'h100);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_n2_if_valid", 32'(s_valid), 32'd0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_n3_if_valid", 32'(s_valid), 32'd1);
    check("redir_n3_if_instr", s_instr, 32'h40);
    check("redir_n3_if_pc_next", s_pcn, 32'h104);

    // Redirect and pop together with a full queue.
    do_reset();
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 32'h0, 1'b0);
    check("full_before_flush", 32'(s_valid), 32'd1);
    tick(1'b0, 1'b1, 32'h200, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("flush_n1_if_valid", 32'(s_valid), 32'd0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("flush_n2_if_valid", 32'(s_valid), 32'd0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("flush_n3_if_instr", s_instr, 32'h80);

    // Reset pulse mid-fill.
    do_reset();
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    check("midrst_rom_en", 32'(s_en), 32'd0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("midrst_if_valid", 32'(s_valid), 32'd0);
    check("midrst_rom_addr", s_addr, ResetPc);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("midrst_if_valid_later", 32'(s_valid), 32'd1);
    check("midrst_if_instr", s_instr, 32'd0);

    // J instruction at 0x8 with target field 0x40.
    jump_word_en = 1'b1;
    do_reset();
    delivered.delete();
    for (int k = 0; k < 12; k++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("jump_enough_delivered", 32'(delivered.size() >= 4), 32'd1);
    if (delivered.size() >= 4) begin
      check("jump_enqueued", delivered[2], JWord);
`ifdef PREFETCH_JUMP_EN
      check("jump_follow", delivered[3], 32'h40);
`else
      check("jump_follow", delivered[3], 32'h3);
`endif
    end
    jump_word_en = 1'b0;

    // Randomized traffic against the delivery-stream model.
    do_reset();
    pops_before = n_pops;
    for (int k = 0; k < 400; k++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 19) == 0);
      ra  = 32'($urandom_range(0, 1023)) << 2;
      tick(1'b0, rd, ra, rdy);
    end
    check("random_progress", 32'((n_pops - pops_before) > 50), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
